branch_target_buffer: RTL and testbench

Direct-mapped branch target buffer in the fetch stage, beside the 2-bit direction predictor. Each cycle it looks up the fetch PC, drives the predictor's entry index and combines the predictor's taken bit with the stored target to produce the predicted next PC. Resolved BEQ/BNE outcomes from the memory stage write it. A multi-cycle flush sweep clears it on a context or code change.

---
 rtl/branch_target_buffer.sv | 106 ++++++++++
 tb/tb_branch_target_buffer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer for the fetch stage. Looks up the fetch PC,
// predicts the next PC, learns taken branches, and clears itself with a flush sweep.
module branch_target_buffer #(
  parameter int ENTRIES = 4,
  parameter int AW      = 32
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic [AW-1:0]              ifpc,
  input  logic                       prtaken,
  output logic [$clog2(ENTRIES)-1:0] ifprindex,
  output logic                       hit,
  output logic                       predtaken,
  output logic [AW-1:0]              npc_pred,
  input  logic                       mmupd,
  input  logic [AW-1:0]              mmpc,
  input  logic [AW-1:0]              mmtarget,
  input  logic                       mmtaken,
  input  logic                       flush_req,
  output logic                       flush_busy
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = AW - IDX - 2;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t               state, state_nxt;
  logic [IDX-1:0]       ptr, ptr_nxt;
  logic [ENTRIES-1:0]   valid;
  logic [TW-1:0]        tag_mem    [ENTRIES];
  logic [AW-1:0]        target_mem [ENTRIES];

  logic [IDX-1:0]       lk_idx, up_idx;
  logic [TW-1:0]        lk_tag, up_tag;
  logic                 wr_en;

  // The word-offset bits of both PCs play no part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, ifpc[1:0], mmpc[1:0]};

  assign lk_idx = ifpc[IDX+1:2];
  assign lk_tag = ifpc[AW-1:IDX+2];
  assign up_idx = mmpc[IDX+1:2];
  assign up_tag = mmpc[AW-1:IDX+2];

  // Only IDLE accepts updates, and a simultaneous flush request pre-empts them.
  assign wr_en = mmupd & mmtaken & (state == IDLE) & ~flush_req;

  assign flush_busy = (state == SWEEP);
  assign ifprindex  = lk_idx;
  assign hit        = valid[lk_idx] & (tag_mem[lk_idx] == lk_tag) & ~flush_busy;
  assign predtaken  = hit & prtaken;
  assign npc_pred   = predtaken ? target_mem[lk_idx] : ifpc + AW'(4);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of block ordering.
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_nxt = state;
    ptr_nxt   = ptr;
    unique case (state)
      IDLE: begin
        if (flush_req) begin
          state_nxt = SWEEP;
          ptr_nxt   = '0;
        end
      end
      SWEEP: begin
        ptr_nxt = ptr + IDX'(1);
        if (ptr == IDX'(ENTRIES - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
    end else if (state == SWEEP) begin
      valid[ptr] <= 1'b0;
    end else if (wr_en) begin
      valid[up_idx] <= 1'b1;
    end
  end

  // NOTE: tag and target storage is deliberately left unreset; the valid bits
  // alone decide whether its contents are ever used, so it can map to plain RAM.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tag_mem[up_idx]    <= up_tag;
      target_mem[up_idx] <= mmtarget;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (ENTRIES=4, AW=32).
module tb_branch_target_buffer;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] ifpc;
  logic        prtaken;
  logic [1:0]  ifprindex;
  logic        hit;
  logic        predtaken;
  logic [31:0] npc_pred;
  logic        mmupd;
  logic [31:0] mmpc;
  logic [31:0] mmtarget;
  logic        mmtaken;
  logic        flush_req;
  logic        flush_busy;

  int errors = 0;
  int checks = 0;

  branch_target_buffer #(.ENTRIES(4), .AW(32)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .ifpc       (ifpc),
    .prtaken    (prtaken),
    .ifprindex  (ifprindex),
    .hit        (hit),
    .predtaken  (predtaken),
    .npc_pred   (npc_pred),
    .mmupd      (mmupd),
    .mmpc       (mmpc),
    .mmtarget   (mmtarget),
    .mmtaken    (mmtaken),
    .flush_req  (flush_req),
    .flush_busy (flush_busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled mid-low-phase.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic learn(input logic [31:0] pc, input logic [31:0] target);
    mmupd = 1'b1; mmpc = pc; mmtarget = target; mmtaken = 1'b1;
    tick();
    mmupd = 1'b0; mmtaken = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic pt,
                        input logic exp_hit, input logic [31:0] exp_npc);
    ifpc = pc; prtaken = pt;
    #1;
    check({tag, "_hit"}, 32'(hit), 32'(exp_hit));
    check({tag, "_npc"}, npc_pred, exp_npc);
  endtask

  int busy_cycles;

  initial begin
    nRST = 1'b0; ifpc = 32'h40; prtaken = 1'b1;
    mmupd = 1'b0; mmpc = '0; mmtarget = '0; mmtaken = 1'b0; flush_req = 1'b0;
    #1;
    check("rst_hit",  32'(hit), 32'd0);
    check("rst_pt",   32'(predtaken), 32'd0);
    check("rst_busy", 32'(flush_busy), 32'd0);
    check("rst_npc",  npc_pred, 32'h44);
    @(negedge CLK); @(negedge CLK);
    nRST = 1'b1;
    tick();

    // Cold lookup misses even when the predictor says taken.
    lookup("cold", 32'h40, 1'b1, 1'b0, 32'h44);
    check("cold_idx", 32'(ifprindex), 32'd0);

    // Same-cycle lookup of the entry being written still sees the old contents.
    ifpc = 32'h44;
    mmupd = 1'b1; mmpc = 32'h44; mmtarget = 32'h100; mmtaken = 1'b1;
    #1;
    check("samecyc_hit", 32'(hit), 32'd0);
    tick();
    mmupd = 1'b0; mmtaken = 1'b0;
    lookup("learn_t", 32'h44, 1'b1, 1'b1, 32'h100);
    check("learn_idx", 32'(ifprindex), 32'd1);
    check("learn_pt",  32'(predtaken), 32'd1);
    lookup("learn_nt", 32'h44, 1'b0, 1'b1, 32'h48);
    check("learn_nt_pt", 32'(predtaken), 32'd0);

    // Alias on index 1 with a different tag, then overwrite.
    lookup("alias_miss", 32'h54, 1'b1, 1'b0, 32'h58);
    learn(32'h54, 32'h200);
    lookup("alias_new", 32'h54, 1'b1, 1'b1, 32'h200);
    lookup("alias_old", 32'h44, 1'b1, 1'b0, 32'h48);

    // Not-taken resolution must not allocate.
    mmupd = 1'b1; mmpc = 32'h48; mmtarget = 32'h400; mmtaken = 1'b0;
    tick();
    mmupd = 1'b0;
    lookup("nt_upd", 32'h48, 1'b1, 1'b0, 32'h4C);

    // Fill all four entries.
    learn(32'h40, 32'h300);
    learn(32'h48, 32'h400);
    learn(32'h4C, 32'h500);
    lookup("full0", 32'h40, 1'b1, 1'b1, 32'h300);
    lookup("full1", 32'h54, 1'b1, 1'b1, 32'h200);
    lookup("full2", 32'h48, 1'b1, 1'b1, 32'h400);
    lookup("full3", 32'h4C, 1'b1, 1'b1, 32'h500);

    // Flush sweep: re-request and a late update for the already-cleared entry 0
    // must both be ignored while busy.
    ifpc = 32'h4C; prtaken = 1'b1;
    flush_req = 1'b1;
    busy_cycles = 0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      flush_req = (c == 2);
      mmupd     = (c == 4);
      mmtaken   = (c == 4);
      mmpc      = 32'h40;
      mmtarget  = 32'h600;
      #1;
      if (flush_busy) begin
        busy_cycles++;
        check("sweep_hit", 32'(hit), 32'd0);
      end
    end
    mmupd = 1'b0; mmtaken = 1'b0; flush_req = 1'b0;
    check("sweep_len", 32'(busy_cycles), 32'd4);
    lookup("post0", 32'h40, 1'b1, 1'b0, 32'h44);
    lookup("post1", 32'h54, 1'b1, 1'b0, 32'h58);
    lookup("post2", 32'h48, 1'b1, 1'b0, 32'h4C);
    lookup("post3", 32'h4C, 1'b1, 1'b0, 32'h50);

    // Flush and update arriving together in IDLE: flush wins.
    flush_req = 1'b1;
    mmupd = 1'b1; mmpc = 32'h40; mmtarget = 32'h700; mmtaken = 1'b1;
    tick();
    flush_req = 1'b0; mmupd = 1'b0; mmtaken = 1'b0;
    check("fu_busy", 32'(flush_busy), 32'd1);
    for (int c = 0; c < 5; c++) tick();
    check("fu_idle", 32'(flush_busy), 32'd0);
    lookup("fu_drop", 32'h40, 1'b1, 1'b0, 32'h44);

    // Address wrap on a miss.
    lookup("wrap", 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0);

    // Reset during the second sweep cycle: entries 2 and 3 not yet swept.
    learn(32'h48, 32'h400);
    learn(32'h4C, 32'h500);
    lookup("pre_rst3", 32'h4C, 1'b1, 1'b1, 32'h500);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    #1;
    check("rst_mid_busy_pre", 32'(flush_busy), 32'd1);
    nRST = 1'b0;
    #1;
    check("rst_mid_busy", 32'(flush_busy), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    tick();
    check("rst_abort_busy", 32'(flush_busy), 32'd0);
    lookup("rst_inv2", 32'h48, 1'b1, 1'b0, 32'h4C);
    lookup("rst_inv3", 32'h4C, 1'b1, 1'b0, 32'h50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
